// File: rtl/alu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_seq : handshaked sequential ALU with an iterative signed multiply
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_seq #(
  parameter int BUS_LEN   = 8,
  parameter int SHAMT_LEN = $clog2(BUS_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BUS_LEN-1:0] A,
  input  logic [BUS_LEN-1:0] B,
  input  logic [5:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BUS_LEN-1:0] out,
  output logic [BUS_LEN-1:0] out_hi,
  output logic [3:0]         flags,
  output logic               err
);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_MULT = 6'b011000;

  localparam int                 MSB      = BUS_LEN - 1;
  localparam int                 CNT_W    = $clog2(BUS_LEN);
  localparam logic [BUS_LEN-1:0] LEN_W    = BUS_LEN'(BUS_LEN);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BUS_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                   accept;
  logic                   is_mult;
  logic                   last_iter;
  logic [CNT_W-1:0]       cnt;
  logic [2*BUS_LEN-1:0]   acc;
  logic [2*BUS_LEN-1:0]   mcand;
  logic [BUS_LEN-1:0]     mplier;
  logic [2*BUS_LEN-1:0]   partial;
  logic [2*BUS_LEN-1:0]   acc_nxt;

  logic [BUS_LEN:0]       add_ext;
  logic [BUS_LEN-1:0]     diff;
  logic [SHAMT_LEN-1:0]   sra_amt;
  logic [BUS_LEN-1:0]     alu_res;
  logic                   alu_ovf;
  logic                   alu_carry;
  logic                   alu_err;
  logic [3:0]             alu_flags;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mult   = (opcode == OP_MULT);
  assign last_iter = (state == MUL) && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mult ? MUL : DONE;
      MUL:  if (last_iter) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = is_mult ? MUL : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign add_ext = {1'b0, A} + {1'b0, B};
  assign diff    = A - B;
  assign sra_amt = SHAMT_LEN'(B % LEN_W);

  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res   = add_ext[BUS_LEN-1:0];
        alu_carry = add_ext[BUS_LEN];
        alu_ovf   = (A[MSB] == B[MSB]) && (add_ext[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res   = diff;
        alu_carry = (A < B);
        alu_ovf   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SRA:  alu_res = $signed(A) >>> sra_amt;
      OP_SRL:  alu_res = (B >= LEN_W) ? '0 : (A >> B);
      OP_SLL:  alu_res = (B >= LEN_W) ? '0 : (A << B);
      OP_SLT:  alu_res = {{(BUS_LEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MULT: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
    // Unrecognised opcodes report all-zero flags, including zero.
    alu_flags = alu_err ? 4'b0000
                        : {alu_ovf, alu_carry, alu_res[MSB], (alu_res == '0)};
  end

  // Shift-add over B's bits; the MSB carries negative weight, so the last step subtracts.
  assign partial = mplier[0] ? mcand : '0;
  assign acc_nxt = (cnt == LAST_CNT) ? (acc - partial) : (acc + partial);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out    <= '0;
      out_hi <= '0;
      flags  <= '0;
      err    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept) begin
      if (is_mult) begin
        acc    <= '0;
        mcand  <= {{BUS_LEN{A[MSB]}}, A};
        mplier <= B;
        cnt    <= '0;
      end else begin
        out    <= alu_res;
        out_hi <= '0;
        flags  <= alu_flags;
        err    <= alu_err;
      end
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last_iter) begin
        out    <= acc_nxt[BUS_LEN-1:0];
        out_hi <= acc_nxt[2*BUS_LEN-1:BUS_LEN];
        flags  <= {2'b00, acc_nxt[2*BUS_LEN-1], (acc_nxt == '0)};
        err    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_MULT = 6'b011000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [5:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic [3:0]   flags;
  logic         err;

  // {out_valid, err, flags(ovf,carry,neg,zero), out_hi, out}
  logic [21:0]  obs;
  assign obs = {out_valid, err, flags, out_hi, out};

  int total = 0;
  int bad   = 0;

  alu_seq #(.BUS_LEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  // Present one op with out_ready low; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op);
    @(negedge clk);
    A = a; B = b; opcode = op; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
    send(a, b, OP_MULT);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    A = 8'h01; B = 8'h01; opcode = OP_ADD;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== 22'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 22'h0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_add;
    logic [21:0] exp;
    send(8'h7F, 8'h01, OP_ADD);
    exp = {1'b1, 1'b0, 4'b1010, 8'h00, 8'h80};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL add_ovf got=%h want=%h", obs, exp); end
    consume;
    send(8'hFF, 8'h01, OP_ADD);
    exp = {1'b1, 1'b0, 4'b0101, 8'h00, 8'h00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL add_carry got=%h want=%h", obs, exp); end
    consume;
  endtask

  task automatic test_sub_slt;
    logic [21:0] exp;
    send(8'h05, 8'h07, OP_SUB);
    exp = {1'b1, 1'b0, 4'b0110, 8'h00, 8'hFE};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sub_borrow got=%h want=%h", obs, exp); end
    consume;
    send(8'hFE, 8'h01, OP_SLT);
    exp = {1'b1, 1'b0, 4'b0000, 8'h00, 8'h01};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL slt_signed got=%h want=%h", obs, exp); end
    consume;
  endtask

  task automatic test_shifts;
    logic [21:0] exp;
    send(8'h80, 8'h09, OP_SRA);
    exp = {1'b1, 1'b0, 4'b0010, 8'h00, 8'hC0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sra_mod got=%h want=%h", obs, exp); end
    consume;
    send(8'h80, 8'h09, OP_SRL);
    exp = {1'b1, 1'b0, 4'b0001, 8'h00, 8'h00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL srl_big got=%h want=%h", obs, exp); end
    consume;
    send(8'h01, 8'h07, OP_SLL);
    exp = {1'b1, 1'b0, 4'b0010, 8'h00, 8'h80};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sll_7 got=%h want=%h", obs, exp); end
    consume;
    send(8'h12, 8'h34, 6'b111111);
    exp = {1'b1, 1'b1, 4'b0000, 8'h00, 8'h00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL bad_opcode got=%h want=%h", obs, exp); end
    consume;
  endtask

  task automatic test_mult;
    int          cyc;
    logic [21:0] exp;
    run_mult(8'hFD, 8'h05, cyc);
    total++;
    if (cyc !== 8) begin bad++; $display("FAIL mult_latency got=%0d want=8", cyc); end
    exp = {1'b1, 1'b0, 4'b0010, 8'hFF, 8'hF1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mult_neg got=%h want=%h", obs, exp); end
    consume;
    run_mult(8'h80, 8'h80, cyc);
    total++;
    if (cyc !== 8) begin bad++; $display("FAIL mult_latency2 got=%0d want=8", cyc); end
    exp = {1'b1, 1'b0, 4'b0000, 8'h40, 8'h00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mult_minmin got=%h want=%h", obs, exp); end
    consume;
  endtask

  task automatic test_mult_reset;
    logic        seen;
    logic [21:0] exp;
    send(8'h07, 8'h07, OP_MULT);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 22'h0) begin bad++; $display("FAIL mulrst_clear got=%h want=%h", obs, 22'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL mulrst_no_valid got=%b want=0", seen); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mulrst_idle got=%b want=1", in_ready); end
    send(8'h02, 8'h03, OP_ADD);
    exp = {1'b1, 1'b0, 4'b0000, 8'h00, 8'h05};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mulrst_after got=%h want=%h", obs, exp); end
    consume;
  endtask

  task automatic test_backpressure;
    logic [22:0] exp_hold;
    logic [21:0] exp;
    send(8'h01, 8'h02, OP_ADD);
    A = 8'h09; B = 8'h04; opcode = OP_SUB; in_valid = 1'b1; out_ready = 1'b0;
    exp_hold = {1'b0, 1'b1, 1'b0, 4'b0000, 8'h00, 8'h03};
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({in_ready, obs} !== exp_hold) begin
        bad++; $display("FAIL bp_hold%0d got=%h want=%h", i, {in_ready, obs}, exp_hold);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    exp = {1'b1, 1'b0, 4'b0000, 8'h00, 8'h05};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL bp_new_op got=%h want=%h", obs, exp); end
    consume;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av [4];
    logic [W-1:0] bv [4];
    logic [5:0]   ov [4];
    logic [W-1:0] ev [4];
    av = '{8'h01, 8'hF0, 8'hF0, 8'h00};
    bv = '{8'h01, 8'hFF, 8'h3C, 8'h00};
    ov = '{OP_ADD, OP_XOR, OP_AND, OP_NOR};
    ev = '{8'h02, 8'h0F, 8'h30, 8'hFF};
    @(negedge clk);
    A = av[0]; B = bv[0]; opcode = ov[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, out} !== {1'b1, 1'b1, ev[i]}) begin
        bad++;
        $display("FAIL b2b_%0d got=%h want=%h", i, {in_ready, out_valid, out}, {1'b1, 1'b1, ev[i]});
      end
      if (i < 3) begin
        A = av[i+1]; B = bv[i+1]; opcode = ov[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_shifts();
    test_mult();
    test_mult_reset();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
